// File: rtl/fetch_queue_if.sv
// Instruction channel between fetch and decode: one entry plus a valid/ready handshake.
// Purely structural; it has no latency and no state.
// The master drives valid and the entry fields, and the slave drives ready.
interface fetch_queue_if #(
  parameter int XLEN = 32
);

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst;
  logic            is_comp;
  logic            spec_taken;
  logic [XLEN-1:0] spec_pc;

  // The side producing instructions (fetch, or the queue towards decode).
  modport master (
    output valid,
    output pc,
    output inst,
    output is_comp,
    output spec_taken,
    output spec_pc,
    input  ready
  );

  // The side consuming instructions (the queue from fetch, or decode).
  modport slave (
    input  valid,
    input  pc,
    input  inst,
    input  is_comp,
    input  spec_taken,
    input  spec_pc,
    output ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode; a flush drops every entry.
// Latency is 1 cycle from enqueue to head, or 0 cycles into an empty queue with FETCH_QUEUE_BYPASS_EN.
// enq.ready depends only on registered occupancy. deq.valid is gated by flush_i in the same cycle.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  fetch_queue_if.slave                 enq,
  fetch_queue_if.master                deq,
  output logic [XLEN-1:0]              deq_pc_incr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            is_comp;
    logic            spec_taken;
    logic [XLEN-1:0] spec_pc;
  } entry_t;

  // Storage is never reset. Only entries below count are ever observed.
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               enq_fire;
  logic               deq_fire;
  logic               store_en;
  logic               pop_en;
  logic               head_vld;
  entry_t             in_entry;
  entry_t             head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Pack the incoming fetch fields so that one write moves the whole entry.
  always_comb begin
    in_entry            = '0;
    in_entry.pc         = enq.pc;
    in_entry.inst       = enq.inst;
    in_entry.is_comp    = enq.is_comp;
    in_entry.spec_taken = enq.spec_taken;
    in_entry.spec_pc    = enq.spec_pc;
  end

  // Ready comes only from occupancy, so it has no path from deq.ready back to fetch.
  assign enq.ready = !full;

  // Choose the head entry. The bypass build lets an enqueue into an empty queue fall through.
  always_comb begin
    head     = mem[rd_ptr];
    head_vld = !empty && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty) begin
      head     = in_entry;
      head_vld = enq.valid && !flush_i;
    end
`endif
  end

  assign enq_fire = enq.valid && !full && !flush_i;
  assign deq_fire = head_vld && deq.ready;

  // Work out whether storage is written and whether the head advances.
  // A consumed fall-through entry does neither.
  always_comb begin
    store_en = enq_fire;
    pop_en   = deq_fire;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && deq_fire) begin
      store_en = 1'b0;
      pop_en   = 1'b0;
    end
`endif
  end

  // Write the accepted entry into the slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (store_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Update the pointers and occupancy. Reset and flush both empty the queue, and reset takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({store_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drive the head onto decode, or drive zeros when nothing is valid.
  always_comb begin
    deq.valid      = head_vld;
    deq.pc         = '0;
    deq.inst       = '0;
    deq.is_comp    = 1'b0;
    deq.spec_taken = 1'b0;
    deq.spec_pc    = '0;
    deq_pc_incr_o  = '0;
    if (head_vld) begin
      deq.pc         = head.pc;
      deq.inst       = head.inst;
      deq.is_comp    = head.is_comp;
      deq.spec_taken = head.spec_taken;
      deq.spec_pc    = head.spec_pc;
      deq_pc_incr_o  = head.pc + (head.is_comp ? XLEN'(2) : XLEN'(4));
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_comp;
    logic        spec_taken;
    logic [31:0] spec_pc;
  } ent_t;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc_incr;
  logic [CW-1:0]   count;

  fetch_queue_if #(.XLEN(XLEN)) enq_if ();
  fetch_queue_if #(.XLEN(XLEN)) deq_if ();

  assign deq_if.ready = deq_ready;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .enq           (enq_if),
    .deq           (deq_if),
    .deq_pc_incr_o (deq_pc_incr),
    .count_o       (count)
  );

  always #5 clk_i = ~clk_i;

  ent_t model_q[$];
  ent_t cur;
  int   checks   = 0;
  int   failures = 0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_in(input bit v, input ent_t e, input bit rdy, input bit fl);
    cur                 = e;
    enq_if.valid        = v;
    enq_if.pc           = e.pc;
    enq_if.inst         = e.inst;
    enq_if.is_comp      = e.is_comp;
    enq_if.spec_taken   = e.spec_taken;
    enq_if.spec_pc      = e.spec_pc;
    deq_ready           = rdy;
    flush_i             = fl;
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic comp);
    ent_t e;
    e.pc = pc; e.inst = inst; e.is_comp = comp;
    e.spec_taken = inst[0]; e.spec_pc = pc ^ 32'h0000_0100;
    return e;
  endfunction

  // One clock: the bench enters at the negedge with the inputs already set, and returns at the next negedge.
  task automatic tick(input bit do_chk);
    int          sz;
    bit          byp_now, ev, enq_acc, deq_acc;
    ent_t        hd;
    logic [31:0] incr;
    #1;
    sz      = model_q.size();
    byp_now = BYP && (sz == 0) && enq_if.valid && !flush_i;
    ev      = ((sz != 0) || byp_now) && !flush_i;
    hd      = (sz != 0) ? model_q[0] : cur;
    incr    = hd.pc + (hd.is_comp ? 32'd2 : 32'd4);
    if (do_chk) begin
      chk("count",     64'(count),        64'(sz));
      chk("enq_ready", 64'(enq_if.ready), 64'(sz != DEPTH));
      chk("deq_valid", 64'(deq_if.valid), 64'(ev));
      chk("deq_pc",    64'(deq_if.pc),         ev ? 64'(hd.pc) : 64'd0);
      chk("deq_inst",  64'(deq_if.inst),       ev ? 64'(hd.inst) : 64'd0);
      chk("deq_comp",  64'(deq_if.is_comp),    ev ? 64'(hd.is_comp) : 64'd0);
      chk("deq_taken", 64'(deq_if.spec_taken), ev ? 64'(hd.spec_taken) : 64'd0);
      chk("deq_spc",   64'(deq_if.spec_pc),    ev ? 64'(hd.spec_pc) : 64'd0);
      chk("deq_incr",  64'(deq_pc_incr),       ev ? 64'(incr) : 64'd0);
    end
    enq_acc  = enq_if.valid && (sz < DEPTH) && !flush_i && !rst_ni;
    deq_acc  = ev && deq_ready && !rst_ni;
    last_acc = enq_acc;
    @(posedge clk_i);
    if (rst_ni || flush_i) begin
      model_q.delete();
    end else begin
      if (deq_acc && sz > 0) void'(model_q.pop_front());
      if (enq_acc && !(deq_acc && sz == 0)) model_q.push_back(cur);
    end
    @(negedge clk_i);
  endtask

  ent_t idle;

  initial begin
    idle = mk(32'h0, 32'h0, 1'b0);
    rst_ni = 1'b1;
    set_in(1'b0, idle, 1'b0, 1'b0);
    @(negedge clk_i);
    tick(1'b0);
    tick(1'b0);
    rst_ni = 1'b0;

    // Idle after reset.
    #1;
    chk("tp_idle_valid", 64'(deq_if.valid), 64'd0);
    chk("tp_idle_ready", 64'(enq_if.ready), 64'd1);
    chk("tp_idle_count", 64'(count),        64'd0);
    chk("tp_idle_pc",    64'(deq_if.pc),    64'd0);
    tick(1'b1);

    // A single enqueue is visible on the next cycle.
    set_in(1'b1, mk(32'h4000_0000, 32'h0000_0013, 1'b0), 1'b0, 1'b0);
    tick(1'b1);
    set_in(1'b0, idle, 1'b0, 1'b0);
    #1;
    chk("tp_one_valid", 64'(deq_if.valid), 64'd1);
    chk("tp_one_pc",    64'(deq_if.pc),    64'h4000_0000);
    chk("tp_one_incr",  64'(deq_pc_incr),  64'h4000_0004);
    chk("tp_one_count", 64'(count),        64'd1);
    tick(1'b1);

    // Fill the queue to full; the fifth enqueue is ignored.
    for (int i = 1; i < 4; i++) begin
      set_in(1'b1, mk(32'h4000_0000 + 32'(4 * i), 32'h13 + 32'(i), 1'b0), 1'b0, 1'b0);
      tick(1'b1);
    end
    set_in(1'b1, mk(32'h5000_0000, 32'hdead_beef, 1'b0), 1'b0, 1'b0);
    #1;
    chk("tp_full_count", 64'(count),        64'd4);
    chk("tp_full_ready", 64'(enq_if.ready), 64'd0);
    tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, idle, 1'b1, 1'b0);
      #1;
      chk("tp_drain_pc", 64'(deq_if.pc), 64'h4000_0000 + 64'(4 * i));
      tick(1'b1);
    end
    #1;
    chk("tp_drain_count", 64'(count), 64'd0);

    // Continuous streaming across the pointer wrap, starting with a compressed entry.
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, mk(32'h4000_0010 + 32'(2 * k), 32'h100 + 32'(k), 1'b1), 1'b1, 1'b0);
      #1;
      if (k == (BYP ? 0 : 1)) chk("tp_comp_incr", 64'(deq_pc_incr), 64'h4000_0012);
      tick(1'b1);
    end
    set_in(1'b0, idle, 1'b1, 1'b0);
    tick(1'b1);
    tick(1'b1);

    // Flush at count 3 while an enqueue is offered.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, mk(32'h4000_0100 + 32'(4 * i), 32'h200 + 32'(i), 1'b0), 1'b0, 1'b0);
      tick(1'b1);
    end
    set_in(1'b1, mk(32'h6000_0000, 32'h0bad_0bad, 1'b0), 1'b1, 1'b1);
    #1;
    chk("tp_flush_valid", 64'(deq_if.valid), 64'd0);
    tick(1'b1);
    set_in(1'b0, idle, 1'b1, 1'b0);
    #1;
    chk("tp_postfl_count", 64'(count),        64'd0);
    chk("tp_postfl_ready", 64'(enq_if.ready), 64'd1);
    chk("tp_postfl_valid", 64'(deq_if.valid), 64'd0);
    tick(1'b1);

`ifdef FETCH_QUEUE_BYPASS_EN
    set_in(1'b1, mk(32'h4000_0020, 32'h33, 1'b0), 1'b1, 1'b0);
    #1;
    chk("tp_byp_valid", 64'(deq_if.valid), 64'd1);
    chk("tp_byp_pc",    64'(deq_if.pc),    64'h4000_0020);
    tick(1'b1);
    set_in(1'b0, idle, 1'b0, 1'b0);
    #1;
    chk("tp_byp_count", 64'(count), 64'd0);
    tick(1'b1);
`endif

    // Random traffic with occasional flush and reset; a stalled enqueue holds its entry.
    last_acc = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      ent_t e;
      bit   v;
      if (!enq_if.valid || last_acc) begin
        e = mk({$urandom} & 32'hffff_fffe, $urandom, 1'($urandom_range(0, 1)));
        v = ($urandom_range(0, 9) < 6);
      end else begin
        e = cur;
        v = 1'b1;
      end
      rst_ni = ($urandom_range(0, 199) == 0);
      set_in(v, e, ($urandom_range(0, 1) == 1), ($urandom_range(0, 39) == 0));
      tick(1'b1);
    end
    rst_ni = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between stage1_fetch and stage2_decode.
- Captures each fetched instruction with its pc, compressed flag and branch-prediction info.
- Lets fetch run ahead while decode is stalled, and drops all queued entries on a redirect (flush).
- Circular buffer with ready/valid handshakes on both sides.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  reset; synchronous, active-high (asserted = 1)
- flush_i  input  1  redirect/mispredict; discard all entries
- enq_valid_i  input  1  fetch offers an instruction
- enq_ready_o  output  1  queue can accept (not full)
- enq_pc_i  input  XLEN  instruction pc
- enq_inst_i  input  XLEN  expanded instruction
- enq_is_comp_i  input  1  original instruction was 16-bit
- enq_spec_taken_i  input  1  predictor said taken
- enq_spec_pc_i  input  XLEN  predicted target
- deq_valid_o  output  1  head entry valid
- deq_ready_i  input  1  decode consumes head
- deq_pc_o  output  XLEN  head pc
- deq_pc_incr_o  output  XLEN  head pc + 2 if compressed, else + 4
- deq_inst_o  output  XLEN  head instruction
- deq_is_comp_o  output  1  head compressed flag
- deq_spec_taken_o  output  1  head prediction taken
- deq_spec_pc_o  output  XLEN  head predicted target
- count_o  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst_ni=1 at clock edge): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: deq_valid_o=0, enq_ready_o=1, count_o=0, all deq data outputs 0.
  - Entry storage is not reset.
  - Reset mid-operation discards all entries exactly like flush; reset has priority over flush and over both handshakes.
- enq_ready_o = (count != DEPTH). It is registered-state only: no combinational path from deq_ready_i.
- deq_valid_o = (count != 0) && !flush_i.
- Enqueue fires when enq_valid_i && enq_ready_o && !flush_i:
  - the entry is written at wr_ptr;
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Dequeue fires when deq_valid_o && deq_ready_i; rd_ptr increments modulo DEPTH.
- count update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged when both fire;
  - never exceeds DEPTH or goes below 0.
- Full: enq_valid_i is ignored. Fetch must hold its inputs stable while stalled; the queue drops nothing it has not accepted.
- Simultaneous enqueue and dequeue:
  - when full, enqueue is still blocked (enq_ready_o=0 in that cycle);
  - when empty, the entry is written and becomes visible next cycle (non-bypass build).
- Flush:
  - next cycle wr_ptr=rd_ptr=0 and count=0;
  - any enqueue and dequeue in the flush cycle are suppressed; deq_valid_o=0 in that cycle;
  - enq_ready_o=1 the cycle after the flush.
- Data outputs reflect the head entry when deq_valid_o=1 and are forced to 0 otherwise.
- deq_pc_incr_o is computed combinationally from the head entry (XLEN-bit add, wraps modulo 2^XLEN) and is 0 when invalid.
- Latency: 1 cycle from accepted enqueue into an empty queue to deq_valid_o=1.
- Throughput: 1 entry/cycle sustained on both sides.

Optional Feature:
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0 and enq_valid_i=1 with flush_i=0, the incoming entry appears on the deq outputs in the same cycle (fall-through), with deq_valid_o=1 and data taken from enq_*_i.
  - If deq_ready_i=1 in that cycle, the entry is consumed without being stored: pointers and count unchanged.
  - Otherwise it is stored normally.
  - Latency is 0 cycles when empty.
- FETCH_QUEUE_BYPASS_EN undefined: no bypass; latency is always 1 cycle.

Test Plan:
- Reset, then idle -> deq_valid_o=0, enq_ready_o=1, count_o=0, deq_pc_o=0.
- Enqueue pc=0x4000_0000 inst=0x0000_0013 is_comp=0, deq_ready_i=0 -> next cycle deq_valid_o=1, deq_pc_o=0x4000_0000, deq_pc_incr_o=0x4000_0004, count_o=1.
- Enqueue 4 entries with deq_ready_i=0 -> count_o=4, enq_ready_o=0; a 5th enqueue is ignored. Drain -> pcs emerge in order 0x4000_0000, +4, +8, +C; count_o returns to 0.
- Continuous enqueue and dequeue for 10 cycles (crossing pointer wrap), compressed entry pc=0x4000_0010 -> deq_pc_incr_o=0x4000_0012; order preserved; count_o constant.
- Queue at count 3, flush_i=1 together with enq_valid_i=1 -> deq_valid_o=0 in the flush cycle; next cycle count_o=0, enq_ready_o=1; the flushed enqueue never appears.
- With FETCH_QUEUE_BYPASS_EN, empty queue, enqueue pc=0x4000_0020 with deq_ready_i=1 -> deq_valid_o=1 and deq_pc_o=0x4000_0020 in the same cycle; count_o stays 0.
